// File: rtl/alu_share_arbiter_pkg.sv
// Shared ALUControl code table for the ALU-sharing arbiter and the ALU decoder.
// Single source for the legal-code check; nothing else in the design depends on the encoding.
package alu_share_arbiter_pkg;

    localparam int ALU_CTRL_W = 4;

    typedef logic [ALU_CTRL_W-1:0] alu_ctrl_t;

    localparam alu_ctrl_t ALU_ADD   = 4'b0000;
    localparam alu_ctrl_t ALU_SUB   = 4'b0001;
    localparam alu_ctrl_t ALU_AND   = 4'b0010;
    localparam alu_ctrl_t ALU_OR    = 4'b0011;
    localparam alu_ctrl_t ALU_XOR   = 4'b0100;
    localparam alu_ctrl_t ALU_SLT   = 4'b0101;
    localparam alu_ctrl_t ALU_SLTU  = 4'b0110;
    localparam alu_ctrl_t ALU_AUIPC = 4'b1000;
    localparam alu_ctrl_t ALU_LUI   = 4'b1001;
    localparam alu_ctrl_t ALU_SLL   = 4'b1010;
    localparam alu_ctrl_t ALU_SRA   = 4'b1011;
    localparam alu_ctrl_t ALU_SRL   = 4'b1100;

    function automatic logic alu_ctrl_legal(input alu_ctrl_t code);
        case (code)
            ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLTU,
            ALU_AUIPC, ALU_LUI, ALU_SLL, ALU_SRA, ALU_SRL: alu_ctrl_legal = 1'b1;
            default:                                       alu_ctrl_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Bundle of requester, shared-ALU and response signals around the ALU-sharing arbiter.
// slave = arbiter side, master = requesters / ALU / consumer side.
interface alu_share_arbiter_if #(
    parameter int NREQ = 2,
    parameter int XLEN = 32
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    // Handshakes: a transfer happens on a rising edge where valid & ready are both 1.
    // The source holds valid and its payload stable until that edge; ready may depend on valid.
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*XLEN-1:0] req_a;
    logic [NREQ*XLEN-1:0] req_b;
    logic [NREQ*4-1:0]    req_ctrl;

    logic [XLEN-1:0]      alu_a;
    logic [XLEN-1:0]      alu_b;
    logic [3:0]           alu_ctrl;
    logic [XLEN-1:0]      alu_result;
    logic                 alu_zero;

    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [IDW-1:0]       rsp_id;
    logic [XLEN-1:0]      rsp_result;
    logic                 rsp_zero;
    logic                 rsp_err;

    modport slave (
        input  req_valid, req_a, req_b, req_ctrl, alu_result, alu_zero, rsp_ready,
        output req_ready, alu_a, alu_b, alu_ctrl, rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err
    );

    modport master (
        output req_valid, req_a, req_b, req_ctrl, alu_result, alu_zero, rsp_ready,
        input  req_ready, alu_a, alu_b, alu_ctrl, rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err
    );

endinterface

// File: rtl/alu_share_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or above ptr, wrapping to 0.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx,
    output logic            grant_vld
);

    function automatic int slot(input int p, input int off);
        return (p + off) % NREQ;
    endfunction

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        // Scan from the farthest offset down so the requester nearest ptr overwrites the rest.
        for (int off = NREQ - 1; off >= 0; off--) begin
            if (req[slot(int'(ptr), off)]) begin
                grant                        = '0;
                grant[slot(int'(ptr), off)]  = 1'b1;
                grant_idx                    = IDW'(slot(int'(ptr), off));
                grant_vld                    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one single-cycle ALU among NREQ requesters with a one-deep response buffer.
// Optional ALU_SHARE_STALL_CNT_EN adds a saturating arbitration-stall counter; otherwise stall_cnt is 0.
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int XLEN = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    alu_share_arbiter_if.slave bus,
    output logic [15:0]        stall_cnt
);

    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [IDW-1:0]  ptr_q, ptr_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]  rsp_id_q, rsp_id_d;
    logic [XLEN-1:0] rsp_result_q, rsp_result_d;
    logic            rsp_zero_q, rsp_zero_d;
    logic            rsp_err_q, rsp_err_d;

    logic            can_issue;
    logic [NREQ-1:0] req_elig;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_idx;
    logic            grant_vld;
    alu_ctrl_t       sel_ctrl;
    logic            sel_legal;

    // Grants are suppressed while reset is asserted so req_ready reads 0 during reset.
    assign can_issue = reset_n & (~rsp_valid_q | bus.rsp_ready);
    assign req_elig  = can_issue ? bus.req_valid : '0;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
        .req       (req_elig),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld)
    );

    assign bus.req_ready = grant;

    always_comb begin
        sel_ctrl     = bus.req_ctrl[int'(grant_idx)*ALU_CTRL_W +: ALU_CTRL_W];
        sel_legal    = alu_ctrl_legal(sel_ctrl);
        bus.alu_a    = '0;
        bus.alu_b    = '0;
        bus.alu_ctrl = ALU_ADD;
        if (grant_vld) begin
            bus.alu_a    = bus.req_a[int'(grant_idx)*XLEN +: XLEN];
            bus.alu_b    = bus.req_b[int'(grant_idx)*XLEN +: XLEN];
            bus.alu_ctrl = sel_legal ? sel_ctrl : ALU_ADD;
        end
    end

    always_comb begin
        ptr_d        = ptr_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_err_d    = rsp_err_q;
        if (grant_vld) begin
            ptr_d        = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
            rsp_valid_d  = 1'b1;
            rsp_id_d     = grant_idx;
            rsp_result_d = sel_legal ? bus.alu_result : '0;
            rsp_zero_d   = sel_legal & bus.alu_zero;
            rsp_err_d    = ~sel_legal;
        end else if (bus.rsp_ready) begin
            rsp_valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            ptr_q        <= ptr_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_zero   = rsp_zero_q;
    assign bus.rsp_err    = rsp_err_q;

`ifdef ALU_SHARE_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((|bus.req_valid) && !grant_vld && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= 16'h0000;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: stand-in ALU, cycle-level reference model, literal pins.
module tb_alu_share_arbiter;

    localparam int NREQ = 2;
    localparam int XLEN = 32;

    logic        clk;
    logic        reset_n;
    logic [15:0] stall_cnt;

    int errors = 0;
    int checks = 0;

    alu_share_arbiter_if #(.NREQ(NREQ), .XLEN(XLEN)) bus ();

    alu_share_arbiter #(.NREQ(NREQ), .XLEN(XLEN)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus),
        .stall_cnt (stall_cnt)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- stand-in shared ALU ----------------
    function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
        case (c)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd6:    return (a < b) ? 32'd1 : 32'd0;
            4'd8:    return a + b;
            4'd9:    return b;
            4'd10:   return a << b[4:0];
            4'd11:   return 32'($signed(a) >>> b[4:0]);
            4'd12:   return a >> b[4:0];
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic code_ok(input logic [3:0] c);
        return (c <= 4'd6) || (c >= 4'd8 && c <= 4'd12);
    endfunction

    assign bus.alu_result = alu_fn(bus.alu_a, bus.alu_b, bus.alu_ctrl);
    assign bus.alu_zero   = (bus.alu_result == 32'd0);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model + per-cycle compare ----------------
    int          m_ptr;
    logic        m_valid;
    int          m_id;
    logic [31:0] m_result;
    logic        m_zero;
    logic        m_err;
    int          m_stall;
    int          m_g;
    logic [1:0]  m_ready;
    logic [31:0] m_a, m_b;
    logic [3:0]  m_c;

    always @(negedge clk) begin
        if (!reset_n) begin
            m_ptr = 0; m_valid = 1'b0; m_id = 0; m_result = '0;
            m_zero = 1'b0; m_err = 1'b0; m_stall = 0;
        end
        chk("mdl_rsp_valid", 64'(bus.rsp_valid), 64'(m_valid));
        chk("mdl_rsp_id", 64'(bus.rsp_id), 64'(m_id));
        chk("mdl_rsp_result", 64'(bus.rsp_result), 64'(m_result));
        chk("mdl_rsp_zero", 64'(bus.rsp_zero), 64'(m_zero));
        chk("mdl_rsp_err", 64'(bus.rsp_err), 64'(m_err));
`ifdef ALU_SHARE_STALL_CNT_EN
        chk("mdl_stall_cnt", 64'(stall_cnt), 64'(m_stall));
`else
        chk("mdl_stall_cnt", 64'(stall_cnt), 64'd0);
`endif
        m_g = -1;
        if (reset_n && (!m_valid || bus.rsp_ready)) begin
            for (int off = 0; off < NREQ; off++) begin
                if (m_g < 0 && bus.req_valid[(m_ptr + off) % NREQ]) m_g = (m_ptr + off) % NREQ;
            end
        end
        m_ready = '0;
        m_a = '0; m_b = '0; m_c = '0;
        if (m_g >= 0) begin
            m_ready[m_g] = 1'b1;
            m_a = bus.req_a[m_g*32 +: 32];
            m_b = bus.req_b[m_g*32 +: 32];
            m_c = bus.req_ctrl[m_g*4 +: 4];
        end
        chk("mdl_req_ready", 64'(bus.req_ready), 64'(m_ready));
        chk("mdl_alu_a", 64'(bus.alu_a), 64'(m_a));
        chk("mdl_alu_b", 64'(bus.alu_b), 64'(m_b));
        chk("mdl_alu_ctrl", 64'(bus.alu_ctrl), code_ok(m_c) ? 64'(m_c) : 64'd0);
        if (reset_n) begin
            if (m_g >= 0) begin
                m_valid  = 1'b1;
                m_id     = m_g;
                m_err    = !code_ok(m_c);
                m_result = m_err ? 32'd0 : alu_fn(m_a, m_b, m_c);
                m_zero   = !m_err && (m_result == 32'd0);
                m_ptr    = (m_g + 1) % NREQ;
            end else begin
                if (bus.rsp_ready) m_valid = 1'b0;
                if (|bus.req_valid && m_stall < 65535) m_stall++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
        bus.req_a[i*32 +: 32] = a;
        bus.req_b[i*32 +: 32] = b;
        bus.req_ctrl[i*4 +: 4] = c;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        reset_n       = 1'b0;
        bus.req_valid = 2'b11;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_ctrl  = '0;
        bus.rsp_ready = 1'b1;

        // Reset with both requesting
        tick();
        sample();
        chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_rsp_result", 64'(bus.rsp_result), 64'd0);
        chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
        tick();
        reset_n       = 1'b1;
        bus.req_valid = 2'b00;
        tick();

        // Fairness: req0 10+20=30, req1 7-7=0
        set_req(0, 32'd10, 32'd20, 4'b0000);
        set_req(1, 32'd7, 32'd7, 4'b0001);
        bus.req_valid = 2'b11;
        for (int k = 0; k < 6; k++) begin
            sample();
            chk("fair_grant", 64'(bus.req_ready), (k % 2 == 0) ? 64'd1 : 64'd2);
            if (k > 0) begin
                chk("fair_rsp_valid", 64'(bus.rsp_valid), 64'd1);
                chk("fair_rsp_id", 64'(bus.rsp_id), 64'((k - 1) % 2));
            end
            tick();
        end
        bus.req_valid = 2'b00;
        sample();
        chk("fair_last_id", 64'(bus.rsp_id), 64'd1);
        chk("fair_last_zero", 64'(bus.rsp_zero), 64'd1);
        tick();

        // Single request: 5 - 3 = 2
        set_req(0, 32'd5, 32'd3, 4'b0001);
        bus.req_valid = 2'b01;
        sample();
        chk("single_ready", 64'(bus.req_ready), 64'd1);
        chk("single_alu_ctrl", 64'(bus.alu_ctrl), 64'd1);
        tick();
        bus.req_valid = 2'b00;
        sample();
        chk("single_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        chk("single_rsp_id", 64'(bus.rsp_id), 64'd0);
        chk("single_rsp_result", 64'(bus.rsp_result), 64'd2);
        chk("single_rsp_zero", 64'(bus.rsp_zero), 64'd0);
        chk("single_rsp_err", 64'(bus.rsp_err), 64'd0);
        tick();

        // Backpressure: pointer is at 1, so req1 wins first
        set_req(0, 32'd10, 32'd20, 4'b0000);
        bus.rsp_ready = 1'b0;
        bus.req_valid = 2'b11;
        sample();
        chk("bp_first_grant", 64'(bus.req_ready), 64'd2);
        tick();
        for (int k = 0; k < 4; k++) begin
            sample();
            chk("bp_ready_low", 64'(bus.req_ready), 64'd0);
            chk("bp_hold_id", 64'(bus.rsp_id), 64'd1);
            chk("bp_hold_result", 64'(bus.rsp_result), 64'd0);
            chk("bp_hold_valid", 64'(bus.rsp_valid), 64'd1);
            tick();
        end
        bus.rsp_ready = 1'b1;
        sample();
`ifdef ALU_SHARE_STALL_CNT_EN
        chk("bp_stall_cnt", 64'(stall_cnt), 64'd4);
`else
        chk("bp_stall_cnt", 64'(stall_cnt), 64'd0);
`endif
        chk("bp_drain_grant", 64'(bus.req_ready), 64'd1);
        tick();
        bus.req_valid = 2'b00;
        sample();
        chk("bp_next_valid", 64'(bus.rsp_valid), 64'd1);
        chk("bp_next_id", 64'(bus.rsp_id), 64'd0);
        chk("bp_next_result", 64'(bus.rsp_result), 64'd30);
        tick();

        // Illegal code from req1
        set_req(1, 32'd9, 32'd4, 4'b1111);
        bus.req_valid = 2'b10;
        sample();
        chk("ill_ready", 64'(bus.req_ready), 64'd2);
        chk("ill_alu_ctrl", 64'(bus.alu_ctrl), 64'd0);
        tick();
        bus.req_valid = 2'b00;
        sample();
        chk("ill_rsp_id", 64'(bus.rsp_id), 64'd1);
        chk("ill_rsp_result", 64'(bus.rsp_result), 64'd0);
        chk("ill_rsp_err", 64'(bus.rsp_err), 64'd1);
        tick();

        // Every code through req0: a=0x80000010, b=4
        for (int c = 0; c < 16; c++) begin
            set_req(0, 32'h8000_0010, 32'd4, 4'(c));
            bus.req_valid = 2'b01;
            tick();
            bus.req_valid = 2'b00;
            sample();
            chk("op_err", 64'(bus.rsp_err), (c == 7 || c >= 13) ? 64'd1 : 64'd0);
            if (c == 11) chk("op_sra", 64'(bus.rsp_result), 64'hF800_0001);
            if (c == 2) chk("op_and_zero", 64'(bus.rsp_zero), 64'd1);
            tick();
        end

        // Reset while a response is held
        set_req(0, 32'd1, 32'd1, 4'b0000);
        bus.rsp_ready = 1'b0;
        bus.req_valid = 2'b01;
        tick();
        bus.req_valid = 2'b11;
        reset_n       = 1'b0;
        sample();
        chk("midrst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("midrst_req_ready", 64'(bus.req_ready), 64'd0);
        tick();
        reset_n       = 1'b1;
        bus.rsp_ready = 1'b1;
        sample();
        chk("midrst_grant0", 64'(bus.req_ready), 64'd1);
        tick();
        bus.req_valid = 2'b00;
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
